// File: rtl/shift_reg_pkg.sv
// Shared constants for the right_shift_register block and its storage stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // set1 encoding for the shift stage
  localparam logic MODE_LOAD  = 1'b1;
  localparam logic MODE_SHIFT = 1'b0;

endpackage

// File: rtl/shift_reg_storage.sv
// Output storage stage: captures the shift stage on set2 and drives it out behind en2.
// Latency: 1 clock from set2 to out; en2 gating is combinational (0 clocks).
// Backpressure: none; a capture happens on every set2 edge, gating never disturbs the stored value.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   set2       - capture strobe; oreg takes d on the edge
//   en2        - output enable; out is all zeros when low
//   d          - shift-stage value to capture (pre-edge value)
//   out        - gated storage value
module shift_reg_storage
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set2,
  input  logic             en2,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] oreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      oreg <= '0;
    end else if (set2) begin
      oreg <= d;
    end
  end

  // Gating sits after the register so toggling en2 never loses the stored word.
  assign out = en2 ? oreg : '0;

endmodule

// File: rtl/right_shift_register.sv
// Serial/parallel-in right-shift register with a separate output storage stage (595-style).
// Latency: 1 clock for load/shift to sh_out and for set2 to out; 2 clocks parallel-in to out.
// Backpressure: none; en1 holds the shift stage, en2 blanks out without disturbing storage.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   sh_in      - serial input, enters at the MSB on a shift
//   set1, en1  - shift-stage mode (1 = load in, 0 = shift right) and update enable
//   set2, en2  - storage capture strobe and output enable
//   in         - parallel load data
//   out        - storage stage when en2 = 1, else zero
//   sh_out     - LSB of the shift stage, ungated, for cascading
module right_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sh_in,
  input  logic             set1,
  input  logic             en1,
  input  logic             set2,
  input  logic             en2,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             sh_out
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;

  // in is only selected on a load, so X on in cannot leak into sreg otherwise.
  always_comb begin
    sreg_nxt = sreg;
    if (en1) begin
      if (set1 == MODE_LOAD) begin
        sreg_nxt = in;
      end else begin
        sreg_nxt = {sh_in, sreg[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else begin
      sreg <= sreg_nxt;
    end
  end

  assign sh_out = sreg[0];

  // Storage captures the current (pre-edge) sreg, so a same-edge load and
  // transfer moves the old word to the output while the new one enters sreg.
  shift_reg_storage #(
    .WIDTH (WIDTH)
  ) u_storage (
    .clk  (clk),
    .rst  (rst),
    .set2 (set2),
    .en2  (en2),
    .d    (sreg),
    .out  (out)
  );

endmodule

// File: tb/tb_right_shift_register.sv
// Testbench for right_shift_register: directed test-plan sequences plus randomized
// traffic checked against a behavioural model (8-bit instance) and a WIDTH=4 instance.
module tb_right_shift_register;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst, sh_in, set1, en1, set2, en2;
  logic [7:0] din;
  logic [7:0] dout;
  logic       sh_out;

  // 4-bit instance
  logic       rst4, sh_in4, set1_4, en1_4, set2_4, en2_4;
  logic [3:0] din4;
  logic [3:0] dout4;
  logic       sh_out4;

  right_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .sh_in(sh_in), .set1(set1), .en1(en1),
    .set2(set2), .en2(en2), .in(din), .out(dout), .sh_out(sh_out)
  );

  right_shift_register #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .sh_in(sh_in4), .set1(set1_4), .en1(en1_4),
    .set2(set2_4), .en2(en2_4), .in(din4), .out(dout4), .sh_out(sh_out4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the 8-bit instance
  logic [7:0] m_sreg = 8'h00;
  logic [7:0] m_oreg = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock edge for the 8-bit instance; model computed from current inputs.
  task automatic tick8();
    logic [7:0] ns;
    logic [7:0] no;
    ns = m_sreg;
    no = m_oreg;
    if (rst) begin
      ns = 8'h00;
      no = 8'h00;
    end else begin
      if (en1) begin
        if (set1) ns = din;
        else      ns = (m_sreg >> 1) | (sh_in ? 8'h80 : 8'h00);
      end
      if (set2) no = m_sreg;
    end
    @(posedge clk);
    #1;
    m_sreg = ns;
    m_oreg = no;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out"}, 32'(dout), 32'(en2 ? m_oreg : 8'h00));
    check({tag, "_sh"},  32'(sh_out), 32'(m_sreg[0]));
  endtask

  // Copy sreg into the storage stage without disturbing sreg, then check out.
  task automatic strobe_check(input string tag, input logic [7:0] exp);
    logic s_en1, s_set2, s_en2;
    s_en1 = en1; s_set2 = set2; s_en2 = en2;
    en1 = 1'b0; set2 = 1'b1; en2 = 1'b1;
    tick8();
    check(tag, 32'(dout), 32'(exp));
    en1 = s_en1; set2 = s_set2; en2 = s_en2;
  endtask

  logic [4:0] exp_seq4;

  initial begin
    rst = 1'b1; sh_in = 1'b0; set1 = 1'b0; en1 = 1'b0; set2 = 1'b0; en2 = 1'b0; din = 8'h00;
    rst4 = 1'b1; sh_in4 = 1'b0; set1_4 = 1'b0; en1_4 = 1'b0; set2_4 = 1'b0; en2_4 = 1'b1; din4 = 4'h0;

    // Reset: two edges
    tick8();
    tick8();
    check("rst_out", 32'(dout), 32'h00);
    check("rst_sh", 32'(sh_out), 32'h0);
    check("rst4_out", 32'(dout4), 32'h0);

    // WIDTH=4: load 1001, shift 4 times with sh_in=0 -> sh_out 1,0,0,1,0
    rst4 = 1'b0; en1_4 = 1'b1; set1_4 = 1'b1; din4 = 4'b1001;
    @(posedge clk); #1;
    exp_seq4 = 5'b01001; // bit i = expected sh_out after step i
    check("w4_sh0", 32'(sh_out4), 32'(exp_seq4[0]));
    set1_4 = 1'b0; sh_in4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("w4_sh%0d", i), 32'(sh_out4), 32'(exp_seq4[i]));
    end
    set2_4 = 1'b1; en1_4 = 1'b0;
    @(posedge clk); #1;
    check("w4_out", 32'(dout4), 32'h0);
    set2_4 = 1'b0;

    // Reset released with all controls low: state holds at zero
    rst = 1'b0;
    tick8();
    check("idle_out", 32'(dout), 32'h00);
    check("idle_sh", 32'(sh_out), 32'h0);

    // Load and transfer on the same edges
    en1 = 1'b1; set1 = 1'b1; set2 = 1'b1; en2 = 1'b1; sh_in = 1'b1;
    din = 8'h55; tick8();
    check("lt1_sh", 32'(sh_out), 32'h1);
    check("lt1_out", 32'(dout), 32'h00);
    din = 8'hAA; tick8();
    check("lt2_out", 32'(dout), 32'h55);
    check("lt2_sh", 32'(sh_out), 32'h0);
    tick8();
    check("lt3_out", 32'(dout), 32'hAA);

    // Shift 8'h81 out with sh_in=0
    set2 = 1'b0; din = 8'h81; tick8();
    check("sh_load_sh", 32'(sh_out), 32'h1);
    set1 = 1'b0; sh_in = 1'b0; tick8();
    check("sh1_sh", 32'(sh_out), 32'h0);
    strobe_check("sh1_sreg", 8'h40);
    repeat (7) tick8();
    strobe_check("sh8_sreg", 8'h00);
    sh_in = 1'b1;
    repeat (8) tick8();
    strobe_check("fill_sreg", 8'hFF);
    tick8();
    strobe_check("fill_more", 8'hFF);

    // Hold: en1=0 ignores a pending load
    en1 = 1'b0; set1 = 1'b1; din = 8'h3C; tick8();
    strobe_check("hold_sreg", 8'hFF);
    en2 = 1'b0; #1;
    check("en2_off", 32'(dout), 32'h00);
    en2 = 1'b1; #1;
    check("en2_on", 32'(dout), 32'hFF);

    // Reset mid-operation with oreg = AA
    en1 = 1'b1; set1 = 1'b1; din = 8'hAA; tick8();
    strobe_check("pre_rst", 8'hAA);
    set1 = 1'b0; sh_in = 1'b1; tick8();
    rst = 1'b1; set2 = 1'b1; din = 8'hFF; set1 = 1'b1; tick8();
    check("mid_rst_out", 32'(dout), 32'h00);
    check("mid_rst_sh", 32'(sh_out), 32'h0);
    rst = 1'b0; set2 = 1'b0; din = 8'hC3; tick8();
    check("post_rst_sh", 32'(sh_out), 32'h1);
    strobe_check("post_rst_load", 8'hC3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 24) == 0);
      en1   = 1'($urandom);
      set1  = ($urandom_range(0, 3) == 0);
      set2  = 1'($urandom);
      en2   = ($urandom_range(0, 3) != 0);
      sh_in = 1'($urandom);
      din   = 8'($urandom);
      tick8();
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 7) == 0) begin
        en2 = ~en2; #1;
        check($sformatf("rnd%0d_en2", i), 32'(dout), 32'(en2 ? m_oreg : 8'h00));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
